dmem_resp: RTL and testbench

Data-memory responder: the memory-side end of the load/store request interface, serving one request at a time from the LSU. Accepts a read or write request over a valid/ready channel, inserts a configurable number of wait states, then performs the access on an internal doubleword-organised RAM and returns the full aligned doubleword plus an error flag over a valid/ready response channel. The LSU does byte, half and word extraction and sign extension. Sits between the L/S stage and the backing store.

---
 rtl/dmem_resp.sv | 151 +++++++++++++++
 tb/tb_dmem_resp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, LATENCY wait states, doubleword RAM access.
// Optional misalignment faulting is compiled in with `define DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
  parameter int               XLEN        = 64,
  parameter int               DEPTH_WORDS = 256,
  parameter logic [XLEN-1:0]  BASE_ADDR   = 64'h8000_0000,
  parameter int               LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int              IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH_WORDS) << 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            wr_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic            a_wr;
  logic [XLEN-1:0] a_addr;
  logic [1:0]      a_size;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] off;
  logic [IDX_W-1:0] idx;
  logic            in_range;
  logic            misalign;
  logic            err;
  logic [7:0]      size_mask;
  logic [7:0]      strb;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rd_val;
  logic            do_access;
  logic            we;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // With zero latency the access happens on the accept edge, straight from the request inputs.
  always_comb begin
    a_wr    = (state_q == ST_IDLE) ? req_wr    : wr_q;
    a_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    a_size  = (state_q == ST_IDLE) ? req_size  : size_q;
    a_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

    off      = a_addr - BASE_ADDR;
    in_range = (a_addr >= BASE_ADDR) && (off < SPAN);
    idx      = off[3 +: IDX_W];

    case (a_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    strb     = size_mask << a_addr[2:0];
    wdata_sh = a_wdata << {a_addr[2:0], 3'b000};

`ifdef DMEM_MISALIGN_CHK_EN
    case (a_size)
      2'd1:    misalign = a_addr[0];
      2'd2:    misalign = |a_addr[1:0];
      2'd3:    misalign = |a_addr[2:0];
      default: misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif

    err       = !in_range || misalign;
    do_access = ((state_q == ST_IDLE) && req_valid && (LATENCY == 0)) ||
                ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    we        = do_access && a_wr && !err;
    rd_val    = (err || a_wr) ? '0 : mem[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY);
            if (do_access) begin
              rdata_q <= rd_val;
              err_q   <= err;
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (do_access) begin
            rdata_q <= rd_val;
            err_q   <= err;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM has no reset; lanes shifted past byte 7 fall off the strobe and are dropped.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp (default LATENCY = 1).
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dmem_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Drives one request, scrambles the request inputs after acceptance, waits for the response
  // and completes the handshake (resp_ready is expected high). lat = edges from accept to resp_valid.
  task automatic xact(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                      input logic [63:0] wdata, output logic [63:0] rdata, output logic err,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_size = size; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_size = ~size; req_wdata = ~wdata;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    if (lat >= 20) begin
      n_cmp++; n_mis++;
      $display("FAIL xact_timeout addr=%h: no resp_valid within 20 cycles", addr);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic er; int lat;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'h0) begin n_mis++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_mis++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    @(negedge clk); rst_n = 1'b1;
    xact(1'b1, 64'h8000_0020, 2'd3, 64'hA5A5_0000_5A5A_FFFF, rd, er, lat);
    // Store accepted, then reset while it sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 64'h8000_0020; req_size = 2'd3;
    req_wdata = 64'hDEAD_BEEF_0000_1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL midwait_req_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL midwait_resp_valid got %b want 0", resp_valid); end
    @(negedge clk); rst_n = 1'b1;
    xact(1'b0, 64'h8000_0020, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'hA5A5_0000_5A5A_FFFF) begin n_mis++; $display("FAIL midwait_discard got %h want a5a500005a5affff", rd); end
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL midwait_err got %b want 0", er); end
  endtask

  task automatic test_dword();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0010, 2'd3, 64'h1122_3344_5566_7788, rd, er, lat);
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL sd_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== 64'h0) begin n_mis++; $display("FAIL sd_rdata got %h want 0", rd); end
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL sd_err got %b want 0", er); end
    xact(1'b0, 64'h8000_0010, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL ld_latency got %0d want 1", lat); end
    n_cmp++; if (rd !== 64'h1122_3344_5566_7788) begin n_mis++; $display("FAIL ld_rdata got %h want 1122334455667788", rd); end
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL ld_err got %b want 0", er); end
  endtask

  task automatic test_byte_merge();
    logic [63:0] rd; logic er; int lat;
    // Upper rs2 bits are junk; only the strobed lane may land.
    xact(1'b1, 64'h8000_0013, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL sb_err got %b want 0", er); end
    xact(1'b0, 64'h8000_0010, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h1122_3344_AB66_7788) begin n_mis++; $display("FAIL sb_merge got %h want 11223344ab667788", rd); end
  endtask

  task automatic test_backpressure();
    int waited;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 64'h8000_0010; req_size = 2'd3; req_wdata = 64'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    n_cmp++; if (waited !== 1) begin n_mis++; $display("FAIL bp_latency got %0d want 1", waited); end
    // A request offered while stalled must be ignored.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 64'h8000_0010; req_wdata = 64'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b1) begin n_mis++; $display("FAIL bp_valid[%0d] got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_rdata !== 64'h1122_3344_AB66_7788) begin n_mis++; $display("FAIL bp_rdata[%0d] got %h want 11223344ab667788", i, resp_rdata); end
      n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
    end
    req_valid = 1'b0;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL bp_idle_ready got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_mis++; $display("FAIL bp_idle_valid got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat;
    xact(1'b0, 64'h8000_0010, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h1122_3344_AB66_7788) begin n_mis++; $display("FAIL b2b_stall_store got %h want 11223344ab667788", rd); end
    xact(1'b1, 64'h8000_07F8, 2'd3, 64'h0BAD_F00D_1234_5678, rd, er, lat);
    xact(1'b0, 64'h8000_07F8, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h0BAD_F00D_1234_5678) begin n_mis++; $display("FAIL b2b_last_word got %h want 0badf00d12345678", rd); end
    n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL b2b_last_err got %b want 0", er); end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h8000_0000, 2'd3, 64'h5555_6666_7777_8888, rd, er, lat);
    xact(1'b0, 64'h7FFF_FFF8, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL range_low_err got %b want 1", er); end
    n_cmp++; if (rd !== 64'h0) begin n_mis++; $display("FAIL range_low_rdata got %h want 0", rd); end
    xact(1'b0, 64'h8000_0800, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL range_high_err got %b want 1", er); end
    n_cmp++; if (rd !== 64'h0) begin n_mis++; $display("FAIL range_high_rdata got %h want 0", rd); end
    xact(1'b1, 64'h8000_0800, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL range_st_err got %b want 1", er); end
    xact(1'b0, 64'h8000_0000, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'h5555_6666_7777_8888) begin n_mis++; $display("FAIL range_no_alias got %h want 5555666677778888", rd); end
  endtask

  task automatic test_misalign();
    logic [63:0] rd; logic er; int lat;
    logic [63:0] exp0;
    logic        exp_err;
`ifdef DMEM_MISALIGN_CHK_EN
    exp0 = 64'h0123_4567_89AB_CDEF; exp_err = 1'b1;
`else
    exp0 = 64'hEF23_4567_89AB_CDEF; exp_err = 1'b0;
`endif
    xact(1'b1, 64'h8000_0000, 2'd3, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    xact(1'b1, 64'h8000_0008, 2'd3, 64'hFEDC_BA98_7654_3210, rd, er, lat);
    xact(1'b1, 64'h8000_0007, 2'd1, 64'h0000_0000_0000_BEEF, rd, er, lat);
    n_cmp++; if (er !== exp_err) begin n_mis++; $display("FAIL mis_err got %b want %b", er, exp_err); end
    n_cmp++; if (lat !== 1) begin n_mis++; $display("FAIL mis_latency got %0d want 1", lat); end
    xact(1'b0, 64'h8000_0000, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== exp0) begin n_mis++; $display("FAIL mis_word0 got %h want %h", rd, exp0); end
    xact(1'b0, 64'h8000_0008, 2'd3, 64'h0, rd, er, lat);
    n_cmp++; if (rd !== 64'hFEDC_BA98_7654_3210) begin n_mis++; $display("FAIL mis_word1 got %h want fedcba9876543210", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 64'h0; req_size = 2'd0; req_wdata = 64'h0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_dword();
    test_byte_merge();
    test_backpressure();
    test_back_to_back();
    test_range();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
